// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - memory-mapped 8N1 UART transmitter with byte FIFO
// Bus writes fill the FIFO; the serializer drains it at CLKS_PER_BIT clocks per bit.
module uart_tx_controller #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clkout,
    input  logic        ext_reset,
    input  logic        wen,
    input  logic        ren,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [7:0]      shift;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   baud_cnt;
    logic            full, empty, busy, push, do_push, pop, bit_end;
    logic            unused_bits;

    assign unused_bits = ^data_in[31:8];

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign busy    = (state != IDLE) || !empty;
    assign tx_busy = busy;
    assign push    = wen && (address == 2'd0);
    assign do_push = push && !full;
    assign bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        uart_tx    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                uart_tx = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                uart_tx = shift[0];
                if (bit_end && bit_idx == 3'd7) state_next = STOP;
            end
            STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                shift    <= mem[rd_ptr];
                bit_idx  <= '0;
                baud_cnt <= '0;
            end else if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
                if (state == DATA && bit_end) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clkout) begin
        if (do_push) mem[wr_ptr] <= data_in[7:0];
    end

    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !pop)      count <= count + CW'(1);
            else if (pop && !do_push) count <= count - CW'(1);
            if (push && full)                          overflow <= 1'b1;
            else if (wen && address == 2'd3)           overflow <= 1'b0;
        end
    end

    always_ff @(posedge clkout or negedge ext_reset) begin
        if (!ext_reset) begin
            data_out <= '0;
        end else if (ren) begin
            case (address)
                2'd1:    data_out <= {28'b0, overflow, busy, empty, full};
                2'd2:    data_out <= {{(32-CW){1'b0}}, count};
                default: data_out <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb/tb_uart_tx_controller.sv - scoreboard bench for uart_tx_controller
// A line monitor decodes frames and compares each byte against the write-order queue.
module tb_uart_tx_controller;
    localparam int CPB = 4;

    logic        clkout = 1'b0;
    logic        ext_reset = 1'b0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        uart_tx;
    logic        tx_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mon_frames = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    uart_tx_controller #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .clkout(clkout), .ext_reset(ext_reset), .wen(wen), .ren(ren),
        .address(address), .data_in(data_in), .data_out(data_out),
        .uart_tx(uart_tx), .tx_busy(tx_busy)
    );

    always #5 clkout = ~clkout;
    initial forever begin
        @(posedge clkout);
        cyc++;
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input bit accept);
        wen = 1'b1; address = a; data_in = {24'hDEAD_00, d};
        if (a == 2'd0 && accept) exp_q.push_back(d);
        @(posedge clkout); #1;
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        ren = 1'b1; address = a;
        @(posedge clkout); #1;
        ren = 1'b0;
        v = data_out;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clkout);
        while (tx_busy !== 1'b0 && n < limit) begin
            @(negedge clkout);
            n++;
        end
        check_value("idle_within_budget", {63'b0, tx_busy}, 64'd0);
        repeat (2) @(negedge clkout);
    endtask

    // Line monitor: start detected on first low sample, each bit sampled mid-period.
    initial begin
        bit active = 0;
        int cnt = 0;
        logic [7:0] byte_v = '0;
        forever begin
            @(negedge clkout);
            if (!ext_reset) begin
                active = 0;
            end else if (!active) begin
                if (uart_tx === 1'b0) begin
                    active = 1; cnt = 0;
                    starts.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt % CPB == CPB/2) begin
                    if (cnt / CPB >= 1 && cnt / CPB <= 8) byte_v[cnt/CPB - 1] = uart_tx;
                    if (cnt / CPB == 9) begin
                        check_value("stop_bit", {63'b0, uart_tx}, 64'd1);
                        mon_frames++;
                        if (exp_q.size() == 0) check_value("unexpected_frame", 64'd1, 64'd0);
                        else check_value("rx_byte", {56'b0, byte_v}, {56'b0, exp_q.pop_front()});
                        active = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [39:0] wave_got, wave_exp;
        logic [9:0]  frame;
        int f0;

        // Reset
        repeat (3) @(negedge clkout);
        check_value("rst_uart_tx", {63'b0, uart_tx}, 64'd1);
        check_value("rst_tx_busy", {63'b0, tx_busy}, 64'd0);
        check_value("rst_data_out", {32'b0, data_out}, 64'd0);
        @(posedge clkout); #1;
        ext_reset = 1'b1;
        bus_read(2'd1, v);
        check_value("rst_status", {32'b0, v}, 64'h2);
        bus_read(2'd0, v);
        check_value("rd_addr0_zero", {32'b0, v}, 64'h0);
        check_value("idle_uart_tx", {63'b0, uart_tx}, 64'd1);

        // Single byte 0xA5, exact waveform
        bus_write(2'd0, 8'hA5, 1);
        @(posedge clkout);
        for (int i = 0; i < 40; i++) begin
            @(negedge clkout);
            wave_got[i] = uart_tx;
        end
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) wave_exp[i] = frame[i / CPB];
        check_value("a5_waveform", {24'b0, wave_got}, {24'b0, wave_exp});
        @(negedge clkout);
        check_value("a5_busy_after", {63'b0, tx_busy}, 64'd0);

        // Burst of three, contiguous frames
        wait_idle(200);
        starts.delete();
        bus_write(2'd0, 8'h00, 1);
        bus_write(2'd0, 8'hFF, 1);
        bus_write(2'd0, 8'h55, 1);
        bus_read(2'd2, v);
        check_value("burst_count", {32'b0, v}, 64'd2);
        wait_idle(400);
        check_value("burst_frames", starts.size(), 64'd3);
        if (starts.size() == 3) begin
            check_value("burst_gap1", starts[1] - starts[0], 64'd40);
            check_value("burst_gap2", starts[2] - starts[1], 64'd40);
        end

        // Overflow: 18 quick writes, the 18th is dropped
        f0 = mon_frames;
        for (int i = 0; i < 18; i++) bus_write(2'd0, 8'(8'h10 + i), i < 17);
        bus_read(2'd2, v);
        check_value("ovf_count", {32'b0, v}, 64'd16);
        bus_read(2'd1, v);
        check_value("ovf_status", {32'b0, v}, 64'hD);
        bus_write(2'd3, 8'h00, 0);
        bus_read(2'd1, v);
        check_value("ovf_cleared", {32'b0, v}, 64'h5);
        wait_idle(2000);
        check_value("ovf_frames", mon_frames - f0, 64'd17);
        check_value("ovf_queue_empty", exp_q.size(), 64'd0);

        // Reset mid-frame during DATA of 0x3C
        bus_write(2'd0, 8'h3C, 1);
        bus_write(2'd0, 8'h77, 1);
        repeat (5) @(posedge clkout);
        #1;
        check_value("mid_tx_low", {63'b0, uart_tx}, 64'd0);
        ext_reset = 1'b0;
        exp_q.delete();
        #1;
        check_value("mid_rst_tx_high", {63'b0, uart_tx}, 64'd1);
        check_value("mid_rst_busy", {63'b0, tx_busy}, 64'd0);
        repeat (3) @(posedge clkout);
        #1;
        ext_reset = 1'b1;
        bus_read(2'd2, v);
        check_value("mid_rst_count", {32'b0, v}, 64'd0);
        f0 = mon_frames;
        repeat (100) @(negedge clkout);
        check_value("mid_rst_no_frames", mon_frames - f0, 64'd0);
        check_value("mid_rst_line_idle", {63'b0, uart_tx}, 64'd1);

        // Pointer wrap: 40 random bytes in batches of 10
        f0 = mon_frames;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) bus_write(2'd0, 8'($urandom_range(0, 255)), 1);
            wait_idle(1000);
        end
        check_value("wrap_frames", mon_frames - f0, 64'd40);
        bus_read(2'd2, v);
        check_value("wrap_count", {32'b0, v}, 64'd0);
        bus_read(2'd1, v);
        check_value("wrap_status", {32'b0, v}, 64'h2);
        check_value("wrap_queue_empty", exp_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_controller.md
# uart_tx_controller

Memory-mapped UART transmitter; it is the TX counterpart to the SoC's receive-only UART path and drives the `uart_tx` pin. The CPU writes bytes through the bus into a 16-entry FIFO. An 8N1 serializer drains the FIFO at a fixed baud rate. Status, FIFO level and a sticky overflow flag are readable so firmware can poll before writing.

## Interface
- CLKS_PER_BIT, 234: clkout cycles per bit (27 MHz / 115200 baud); legal values are ≥ 2.
- FIFO_DEPTH, 16: number of entries; must be a power of 2.
- clkout  in  1  system clock.
- ext_reset  in  1  asynchronous, active-low reset.
- wen  in  1  bus write strobe for this peripheral (one cycle per access).
- ren  in  1  bus read strobe for this peripheral.
- address  in  2  register select (data_addr[3:2]).
- data_in  in  32  write data; only [7:0] is used.
- data_out  out  32  registered read data.
- uart_tx  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is being shifted out or the FIFO is non-empty.

## Operation
- Register map:
  - addr 0 (W): push data_in[7:0] into the FIFO. Reads of addr 0 return 0.
  - addr 1 (R): status. {28'b0, overflow, busy, empty, full}.
  - addr 2 (R): FIFO count, zero-extended. Range 0..FIFO_DEPTH; width is $clog2(FIFO_DEPTH+1).
  - addr 3 (W): any write clears `overflow`. Reads of addr 3 return 0.
- FIFO: circular buffer with read/write pointers of width log2(FIFO_DEPTH) that wrap naturally, plus a separate count.
  - full = (count == FIFO_DEPTH).
  - empty = (count == 0).
- Push while full: the byte is dropped, `overflow` is set (sticky), and the pointers and count are unchanged.
  - Full is evaluated on the pre-pop count. A push and a pop in the same cycle while full still drops the byte.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If FIFO non-empty, pop into an 8-bit shift register, clear the bit counter and baud counter, and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: uart_tx=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP. Bits are sent LSB first.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter counts from 0 to CLKS_PER_BIT-1 and wraps to 0 at the end of each bit.
- busy = (state != IDLE) || !empty. tx_busy mirrors this value.
- A write to addr 1 or 2 has no effect.
- A read and a write in the same cycle are both serviced. A read of count or status returns the pre-edge value.

## Timing
- Reset values (asynchronous):
  - uart_tx=1, tx_busy=0, data_out=0, state=IDLE.
  - Pointers, count and overflow are 0. FIFO contents are don't-care.
- Reset asserted mid-frame: uart_tx returns to 1 immediately (asynchronously). Queued bytes are discarded. No partial frame is resumed after release.
- Write latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. uart_tx goes low after edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles, from the falling edge of the start bit to the end of the stop bit.
- Back-to-back bytes: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Read latency: 1 cycle. When ren=1 at edge N, data_out holds the selected value after edge N. data_out holds its value while ren=0.
- Status reflects state registered at the sampling edge. A push at edge N shows in count when read at edge N+1 or later.

## Test plan
- Reset behaviour, with CLKS_PER_BIT=4: hold ext_reset low and release; read addr 1 → 0x2 (empty). uart_tx=1 and tx_busy=0 throughout.
- Single byte 0xA5: write addr 0 → uart_tx shows 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). Each bit lasts exactly 4 cycles; total 40 cycles. Then tx_busy=0.
- Burst of 3 bytes (0x00, 0xFF, 0x55) written on consecutive cycles → 120 contiguous cycles of frames with no idle gap. Count read right after the burst = 2.
- Overflow, with TX held in a long frame: write 18 bytes quickly → count=16 and status bit3=1. Then write addr 3 → bit3=0. Exactly 17 frames are eventually transmitted: 1 popped immediately plus 16 queued, with the 18th byte dropped.
- Reset mid-frame: pull ext_reset low during DATA of byte 0x3C → uart_tx=1 the same cycle. After release, count=0 and no further frames are sent.
- Pointer wrap: send 40 bytes in batches of 10, waiting for empty between batches → all 40 bytes are received correctly by a bench UART monitor. Count returns to 0 and overflow stays 0.
